// File: rtl/mux_scan_demux_pkg.sv
// Shared constants, FSM state type and parameter legality check for the
// mux scan/demux receiver.
package mux_scan_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  function automatic bit params_legal(input int div, input int settle);
    return (div >= 2) && (div <= 256) && (settle >= 1) && (settle <= div - 1);
  endfunction

endpackage

// File: rtl/mux_scan_demux_if.sv
// Frame delivery bus: reconstructed word, valid/ack handshake, frame counter
// and sticky overrun flag.
interface mux_scan_demux_if;
  import mux_scan_pkg::*;

  logic [N_CH-1:0] q;
  logic            frame_valid;
  logic            frame_ack;
  logic [7:0]      frame_cnt;
  logic            overrun;

  modport master (
    output q,
    output frame_valid,
    input  frame_ack,
    output frame_cnt,
    output overrun
  );

  modport slave (
    input  q,
    input  frame_valid,
    output frame_ack,
    input  frame_cnt,
    input  overrun
  );

endinterface

// File: rtl/mux_scan_demux_timer.sv
// Per-slot cycle counter: flags the sample cycle and the last cycle of each
// channel slot; held at zero whenever run is low.
module scan_slot_timer #(
  parameter int DIV    = 4,
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sample_stb,
  output logic slot_end
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign sample_stb = run && (cnt == CW'(SETTLE));
  assign slot_end   = run && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/mux_scan_demux.sv
// Receive-side partner of a 4:1 bit mux: sweeps the select, samples y per
// channel and presents each completed sweep as a handshaked frame.
module mux_scan_demux
  import mux_scan_pkg::*;
#(
  parameter int DIV    = 4,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             y,
  output logic [SEL_W-1:0] sel,
  mux_scan_demux_if.master bus
);

  generate
    if (!params_legal(DIV, SETTLE)) begin : g_bad_params
      $error("mux_scan_demux: illegal DIV/SETTLE combination");
    end
  endgenerate

  state_t          state;
  logic [N_CH-1:0] shadow;
  logic [N_CH-1:0] frame_word;
  logic            run;
  logic            sample_stb;
  logic            slot_end;
  logic            frame_end;

  assign run       = (state == SCAN) && en;
  assign frame_end = slot_end && (sel == SEL_W'(N_CH - 1));

  scan_slot_timer #(
    .DIV    (DIV),
    .SETTLE (SETTLE)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .sample_stb (sample_stb),
    .slot_end   (slot_end)
  );

  // When SETTLE == DIV-1 the last channel is sampled on the frame-end cycle,
  // so that bit has to bypass the shadow register.
  always_comb begin
    frame_word = shadow;
    if (sample_stb) begin
      frame_word[sel] = y;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      sel             <= '0;
      shadow          <= '0;
      bus.q           <= '0;
      bus.frame_valid <= 1'b0;
      bus.frame_cnt   <= '0;
      bus.overrun     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= '0;
          if (en) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (!en) begin
            state  <= IDLE;
            sel    <= '0;
            shadow <= '0;
          end else begin
            if (sample_stb) begin
              shadow[sel] <= y;
            end
            if (slot_end) begin
              sel <= frame_end ? '0 : sel + SEL_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
        end
      endcase

      // A new frame wins over a same-cycle ack: valid stays high, no overrun.
      if (frame_end) begin
        bus.q           <= frame_word;
        bus.frame_valid <= 1'b1;
        bus.frame_cnt   <= bus.frame_cnt + 8'd1;
        if (bus.frame_valid && !bus.frame_ack) begin
          bus.overrun <= 1'b1;
        end
      end else if (bus.frame_valid && bus.frame_ack) begin
        bus.frame_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_demux.sv
// Bench for mux_scan_demux: two instances (DIV=4/SETTLE=2 and DIV=2/SETTLE=1),
// each fed by a behavioural 4:1 mux, with a frame scoreboard per instance.
module tb_mux_scan_demux;
  import mux_scan_pkg::*;

  typedef struct {
    logic [3:0] q;
    logic [7:0] cnt;
    logic       ovr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en_a = 1'b0;
  logic       en_b = 1'b0;
  logic [3:0] a_a = 4'b0000;
  logic [3:0] a_b = 4'b0000;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       y_a;
  logic       y_b;

  int checks = 0;
  int passes = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;
  logic [7:0] prev_a = 8'd0;
  logic [7:0] prev_b = 8'd0;

  always #5 clk = ~clk;

  mux_scan_demux_if bus_a ();
  mux_scan_demux_if bus_b ();

  assign y_a = a_a[sel_a];
  assign y_b = a_b[sel_b];

  mux_scan_demux #(.DIV(4), .SETTLE(2)) dut_a (
    .clk (clk),
    .rst (rst),
    .en  (en_a),
    .y   (y_a),
    .sel (sel_a),
    .bus (bus_a)
  );

  mux_scan_demux #(.DIV(2), .SETTLE(1)) dut_b (
    .clk (clk),
    .rst (rst),
    .en  (en_b),
    .y   (y_b),
    .sel (sel_b),
    .bus (bus_b)
  );

  // Frame delivery is detected as a change of frame_cnt outside reset.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_a = bus_a.frame_cnt;
    end else if (bus_a.frame_cnt !== prev_a) begin
      prev_a = bus_a.frame_cnt;
      checks++;
      if (qa.size() == 0) begin
        $display("FAIL sb_a_unexpected: frame cnt=%0d q=%b, expected no frame", bus_a.frame_cnt, bus_a.q);
      end else begin
        ea = qa.pop_front();
        if ({bus_a.q, bus_a.frame_cnt, bus_a.overrun, bus_a.frame_valid} !== {ea.q, ea.cnt, ea.ovr, 1'b1})
          $display("FAIL sb_a_frame: q=%b cnt=%0d ovr=%b fv=%b, expected q=%b cnt=%0d ovr=%b fv=1",
                   bus_a.q, bus_a.frame_cnt, bus_a.overrun, bus_a.frame_valid, ea.q, ea.cnt, ea.ovr);
        else passes++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst) begin
      prev_b = bus_b.frame_cnt;
    end else if (bus_b.frame_cnt !== prev_b) begin
      prev_b = bus_b.frame_cnt;
      checks++;
      if (qb.size() == 0) begin
        $display("FAIL sb_b_unexpected: frame cnt=%0d q=%b, expected no frame", bus_b.frame_cnt, bus_b.q);
      end else begin
        eb = qb.pop_front();
        if ({bus_b.q, bus_b.frame_cnt, bus_b.overrun, bus_b.frame_valid} !== {eb.q, eb.cnt, eb.ovr, 1'b1})
          $display("FAIL sb_b_frame: q=%b cnt=%0d ovr=%b fv=%b, expected q=%b cnt=%0d ovr=%b fv=1",
                   bus_b.q, bus_b.frame_cnt, bus_b.overrun, bus_b.frame_valid, eb.q, eb.cnt, eb.ovr);
        else passes++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if ({sel_a, bus_a.q, bus_a.frame_valid, bus_a.frame_cnt, bus_a.overrun} !== 16'h0000)
      $display("FAIL reset_a: sel=%0d q=%b fv=%b cnt=%0d ovr=%b, expected all 0",
               sel_a, bus_a.q, bus_a.frame_valid, bus_a.frame_cnt, bus_a.overrun);
    else passes++;
    checks++;
    if ({sel_b, bus_b.q, bus_b.frame_valid, bus_b.frame_cnt, bus_b.overrun} !== 16'h0000)
      $display("FAIL reset_b: sel=%0d q=%b fv=%b cnt=%0d ovr=%b, expected all 0",
               sel_b, bus_b.q, bus_b.frame_valid, bus_b.frame_cnt, bus_b.overrun);
    else passes++;
    rst = 1'b0;
    tick(1);
  endtask

  // Cycle 0 is the cycle in which en=1 is first seen in IDLE.
  task automatic test_basic;
    a_a  = 4'b1010;
    en_a = 1'b1;
    qa.push_back('{q: 4'b1010, cnt: 8'd1, ovr: 1'b0});
    for (int unsigned c = 1; c <= 16; c++) begin
      tick(1);
      checks++;
      if (sel_a !== 2'((c - 1) / 4))
        $display("FAIL basic_sel: cycle %0d sel=%0d, expected %0d", c, sel_a, (c - 1) / 4);
      else passes++;
      if (c == 16) begin
        checks++;
        if (bus_a.frame_valid !== 1'b0)
          $display("FAIL basic_latency: cycle 16 fv=%b, expected 0", bus_a.frame_valid);
        else passes++;
      end
    end
    tick(1);
    checks++;
    if ({bus_a.frame_valid, bus_a.q, bus_a.frame_cnt} !== {1'b1, 4'b1010, 8'd1})
      $display("FAIL basic_frame: fv=%b q=%b cnt=%0d, expected fv=1 q=1010 cnt=1",
               bus_a.frame_valid, bus_a.q, bus_a.frame_cnt);
    else passes++;
  endtask

  task automatic test_simultaneous;
    a_a = 4'b0011;
    qa.push_back('{q: 4'b0011, cnt: 8'd2, ovr: 1'b0});
    tick(15);
    bus_a.frame_ack = 1'b1;
    tick(1);
    bus_a.frame_ack = 1'b0;
    checks++;
    if ({bus_a.frame_valid, bus_a.q, bus_a.overrun} !== {1'b1, 4'b0011, 1'b0})
      $display("FAIL simultaneous: fv=%b q=%b ovr=%b, expected fv=1 q=0011 ovr=0",
               bus_a.frame_valid, bus_a.q, bus_a.overrun);
    else passes++;
  endtask

  task automatic test_overrun;
    a_a = 4'b0101;
    qa.push_back('{q: 4'b0101, cnt: 8'd3, ovr: 1'b1});
    tick(16);
    checks++;
    if ({bus_a.frame_valid, bus_a.q, bus_a.overrun, bus_a.frame_cnt} !== {1'b1, 4'b0101, 1'b1, 8'd3})
      $display("FAIL overrun_frame: fv=%b q=%b ovr=%b cnt=%0d, expected fv=1 q=0101 ovr=1 cnt=3",
               bus_a.frame_valid, bus_a.q, bus_a.overrun, bus_a.frame_cnt);
    else passes++;
    bus_a.frame_ack = 1'b1;
    tick(1);
    checks++;
    if ({bus_a.frame_valid, bus_a.overrun} !== 2'b01)
      $display("FAIL ack_drop: fv=%b ovr=%b, expected fv=0 ovr=1", bus_a.frame_valid, bus_a.overrun);
    else passes++;
    tick(1);
    bus_a.frame_ack = 1'b0;
    checks++;
    if ({bus_a.frame_valid, bus_a.q, bus_a.overrun} !== {1'b0, 4'b0101, 1'b1})
      $display("FAIL ack_idle: fv=%b q=%b ovr=%b, expected fv=0 q=0101 ovr=1",
               bus_a.frame_valid, bus_a.q, bus_a.overrun);
    else passes++;
  endtask

  // Sweep 4 began at cycle 49; this task starts at cycle 51.
  task automatic test_abort;
    tick(7);
    checks++;
    if (sel_a !== 2'd2)
      $display("FAIL abort_pre: sel=%0d, expected 2", sel_a);
    else passes++;
    en_a = 1'b0;
    tick(1);
    checks++;
    if ({sel_a, bus_a.q, bus_a.frame_cnt, bus_a.frame_valid} !== {2'd0, 4'b0101, 8'd3, 1'b0})
      $display("FAIL abort_idle: sel=%0d q=%b cnt=%0d fv=%b, expected sel=0 q=0101 cnt=3 fv=0",
               sel_a, bus_a.q, bus_a.frame_cnt, bus_a.frame_valid);
    else passes++;
    tick(1);
    checks++;
    if (sel_a !== 2'd0)
      $display("FAIL abort_hold: sel=%0d, expected 0", sel_a);
    else passes++;
    a_a  = 4'b1100;
    en_a = 1'b1;
    qa.push_back('{q: 4'b1100, cnt: 8'd4, ovr: 1'b1});
    tick(16);
    checks++;
    if (bus_a.frame_valid !== 1'b0)
      $display("FAIL restart_latency: fv=%b one cycle early, expected 0", bus_a.frame_valid);
    else passes++;
    tick(1);
    checks++;
    if ({bus_a.frame_valid, bus_a.q, bus_a.frame_cnt} !== {1'b1, 4'b1100, 8'd4})
      $display("FAIL restart_frame: fv=%b q=%b cnt=%0d, expected fv=1 q=1100 cnt=4",
               bus_a.frame_valid, bus_a.q, bus_a.frame_cnt);
    else passes++;
  endtask

  task automatic test_reset_mid_scan;
    tick(5);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({sel_a, bus_a.q, bus_a.frame_valid, bus_a.frame_cnt, bus_a.overrun} !== 16'h0000)
      $display("FAIL reset_mid_scan: sel=%0d q=%b fv=%b cnt=%0d ovr=%b, expected all 0",
               sel_a, bus_a.q, bus_a.frame_valid, bus_a.frame_cnt, bus_a.overrun);
    else passes++;
    tick(1);
    en_a = 1'b0;
    rst  = 1'b0;
    tick(1);
  endtask

  // DIV=2: frame k is sampled in cycles 8k-7..8k and appears at 8k+1.
  task automatic test_edge_params;
    logic [3:0] w;
    w = 4'b1000;
    a_b = w;
    qb.push_back('{q: w, cnt: 8'd1, ovr: 1'b0});
    bus_b.frame_ack = 1'b1;
    en_b = 1'b1;
    tick(1);
    for (int k = 1; k <= 257; k++) begin
      tick(7);
      if (k <= 4) begin
        checks++;
        if (bus_b.frame_valid !== 1'b0)
          $display("FAIL edge_period_low: frame %0d fv=%b, expected 0", k, bus_b.frame_valid);
        else passes++;
      end
      tick(1);
      if (k <= 4) begin
        checks++;
        if (bus_b.frame_valid !== 1'b1)
          $display("FAIL edge_period_high: frame %0d fv=%b, expected 1", k, bus_b.frame_valid);
        else passes++;
      end
      if (k == 256) begin
        checks++;
        if (bus_b.frame_cnt !== 8'd0)
          $display("FAIL edge_wrap: frame_cnt=%0d, expected 0", bus_b.frame_cnt);
        else passes++;
      end
      if (k < 257) begin
        w = (k == 1) ? 4'b0111 : 4'($urandom_range(0, 15));
        a_b = w;
        qb.push_back('{q: w, cnt: 8'((k + 1) % 256), ovr: 1'b0});
      end
    end
    en_b = 1'b0;
    bus_b.frame_ack = 1'b0;
    tick(2);
  endtask

  task automatic test_drain;
    checks++;
    if (qa.size() != 0)
      $display("FAIL drain_a: %0d frames outstanding, expected 0", qa.size());
    else passes++;
    checks++;
    if (qb.size() != 0)
      $display("FAIL drain_b: %0d frames outstanding, expected 0", qb.size());
    else passes++;
  endtask

  initial begin
    bus_a.frame_ack = 1'b0;
    bus_b.frame_ack = 1'b0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_overrun();
    test_abort();
    test_reset_mid_scan();
    test_edge_params();
    test_drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
